// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART message transmitter family.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_BIT,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time tick generator: o_tick is high on the last clock of every DIV-clock bit.
// i_clr holds the count at zero so a new start bit begins on a clean boundary.
module uart_baud_gen #(
    parameter int DIV = 87
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    logic [31:0] r_cnt;

    assign o_tick = (r_cnt == 32'(DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/uart_msg_tx.sv
// Serialises a runtime-selected prefix of a writable character buffer as UART frames.
// First start bit appears the clock after start is accepted; done pulses as the last stop bit ends.
module uart_msg_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 10000000,
    parameter int BAUD_RATE   = 115200,
    parameter int MSG_DEPTH   = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int GAP_CYCLES  = 100000,
    parameter int AUTO_REPEAT = 0,
    localparam int AW         = $clog2(MSG_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW:0]   i_msg_len,
    input  logic          i_start,
    input  logic          i_stop_req,
    output logic          o_tx,
    output logic          o_busy,
    output logic [AW-1:0] o_char_idx,
    output logic          o_done
);

    localparam int          BAUD_DIV     = CLK_FREQ / BAUD_RATE;
    localparam logic [3:0]  LP_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LP_LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [AW:0] LP_DEPTH     = (AW + 1)'(MSG_DEPTH);
    localparam logic [31:0] LP_GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [7:0]  LP_MASK      = 8'((1 << DATA_BITS) - 1);

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_mem [MSG_DEPTH];
    logic [AW:0]   r_len;
    logic [AW-1:0] r_char_idx;
    logic [3:0]    r_bit_cnt;
    logic [31:0]   r_gap_cnt;
    logic          r_stop;
    logic          r_done;

    logic          w_tick;
    logic          w_clr;
    logic          w_busy;
    logic          w_tx;
    logic [AW:0]   w_len_clamped;
    logic          w_start_ok;
    logic          w_last_char;
    logic          w_stop_any;
    logic          w_frame_end;
    logic          w_msg_end;
    logic [7:0]    w_data;
    logic          w_parity_bit;

    uart_baud_gen #(.DIV(BAUD_DIV)) u_baud (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    assign w_clr         = (r_state == ST_IDLE) || (r_state == ST_GAP);
    assign w_len_clamped = (i_msg_len > LP_DEPTH) ? LP_DEPTH : i_msg_len;
    assign w_start_ok    = (r_state == ST_IDLE) && i_start;
    assign w_last_char   = ({1'b0, r_char_idx} == (r_len - 1'b1));
    assign w_stop_any    = r_stop || i_stop_req;
    assign w_frame_end   = (r_state == ST_STOP) && w_tick && (r_bit_cnt == LP_LAST_STOP);
    // A pending stop request ends the message after the frame in flight.
    assign w_msg_end     = w_frame_end && (w_last_char || w_stop_any);
    assign w_data        = r_mem[r_char_idx] & LP_MASK;
    assign w_parity_bit  = (PARITY == PAR_ODD) ? ~^w_data : ^w_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok && (w_len_clamped != '0)) begin
                    w_next = ST_START_BIT;
                end
            end
            ST_START_BIT: begin
                if (w_tick) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick && (r_bit_cnt == LP_LAST_DATA)) begin
                    w_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_frame_end) begin
                    if (!w_msg_end) begin
                        w_next = ST_START_BIT;
                    end else if ((AUTO_REPEAT != 0) && !w_stop_any) begin
                        w_next = (GAP_CYCLES == 0) ? ST_START_BIT : ST_GAP;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (r_stop) begin
                    w_next = ST_IDLE;
                end else if (r_gap_cnt == LP_GAP_LAST) begin
                    w_next = ST_START_BIT;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != ST_IDLE);
        w_tx   = 1'b1;
        case (r_state)
            ST_START_BIT: w_tx = 1'b0;
            ST_DATA:      w_tx = w_data[r_bit_cnt[2:0]];
            ST_PARITY:    w_tx = w_parity_bit;
            default:      w_tx = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len      <= '0;
            r_char_idx <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_stop     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (w_start_ok && (w_len_clamped == '0)) || w_msg_end;

            if (w_start_ok) begin
                r_len      <= w_len_clamped;
                r_char_idx <= '0;
            end else if ((r_state == ST_STOP) && (w_next == ST_START_BIT)) begin
                r_char_idx <= (w_msg_end) ? '0 : r_char_idx + 1'b1;
            end else if ((r_state == ST_GAP) && (w_next == ST_START_BIT)) begin
                r_char_idx <= '0;
            end

            if (w_next == ST_IDLE) begin
                r_stop <= 1'b0;
            end else if (i_stop_req && (r_state != ST_IDLE)) begin
                r_stop <= 1'b1;
            end

            // Every phase change restarts the per-phase bit count.
            if (r_state != w_next) begin
                r_bit_cnt <= '0;
            end else if (w_tick && ((r_state == ST_DATA) || (r_state == ST_STOP))) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 32'd1 : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en && !w_busy && (int'(i_wr_addr) < MSG_DEPTH)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_tx       = w_tx;
    assign o_busy     = w_busy;
    assign o_char_idx = r_char_idx;
    assign o_done     = r_done;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Directed bench: three transmitter instances (8N1, 7E2, 8O1 auto-repeat), 10 clocks per bit.
module tb_uart_msg_tx;

    logic       clk = 1'b0;
    logic       rst      [3];
    logic       wr_en    [3];
    logic [3:0] wr_addr  [3];
    logic [7:0] wr_data  [3];
    logic [4:0] msg_len  [3];
    logic       start    [3];
    logic       stop_req [3];
    logic       tx_o     [3];
    logic       busy_o   [3];
    logic [3:0] idx_o    [3];
    logic       done_o   [3];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_mem [16];

    always #5 clk = ~clk;

    uart_msg_tx #(.CLK_FREQ(10000000), .BAUD_RATE(1000000), .MSG_DEPTH(16), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .GAP_CYCLES(100), .AUTO_REPEAT(0)) u_d0 (
        .i_clk(clk), .i_rst(rst[0]), .i_wr_en(wr_en[0]), .i_wr_addr(wr_addr[0]),
        .i_wr_data(wr_data[0]), .i_msg_len(msg_len[0]), .i_start(start[0]),
        .i_stop_req(stop_req[0]), .o_tx(tx_o[0]), .o_busy(busy_o[0]),
        .o_char_idx(idx_o[0]), .o_done(done_o[0]));

    uart_msg_tx #(.CLK_FREQ(10000000), .BAUD_RATE(1000000), .MSG_DEPTH(16), .DATA_BITS(7),
                  .PARITY(2), .STOP_BITS(2), .GAP_CYCLES(100), .AUTO_REPEAT(0)) u_d1 (
        .i_clk(clk), .i_rst(rst[1]), .i_wr_en(wr_en[1]), .i_wr_addr(wr_addr[1]),
        .i_wr_data(wr_data[1]), .i_msg_len(msg_len[1]), .i_start(start[1]),
        .i_stop_req(stop_req[1]), .o_tx(tx_o[1]), .o_busy(busy_o[1]),
        .o_char_idx(idx_o[1]), .o_done(done_o[1]));

    uart_msg_tx #(.CLK_FREQ(10000000), .BAUD_RATE(1000000), .MSG_DEPTH(16), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1), .GAP_CYCLES(50), .AUTO_REPEAT(1)) u_d2 (
        .i_clk(clk), .i_rst(rst[2]), .i_wr_en(wr_en[2]), .i_wr_addr(wr_addr[2]),
        .i_wr_data(wr_data[2]), .i_msg_len(msg_len[2]), .i_start(start[2]),
        .i_stop_req(stop_req[2]), .o_tx(tx_o[2]), .o_busy(busy_o[2]),
        .o_char_idx(idx_o[2]), .o_done(done_o[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int k, input int a, input logic [7:0] d);
        @(negedge clk);
        wr_en[k]   = 1'b1;
        wr_addr[k] = 4'(a);
        wr_data[k] = d;
        @(negedge clk);
        wr_en[k]   = 1'b0;
    endtask

    // Returns on the first negedge after start was sampled: the first start-bit clock.
    task automatic kick(input int k, input int len, input logic hold);
        @(negedge clk);
        msg_len[k] = 5'(len);
        start[k]   = 1'b1;
        @(negedge clk);
        start[k]   = hold;
    endtask

    // Walks one frame bit by bit, 10 clocks each; optionally pulses stop_req in bit stop_at.
    task automatic frame(input int k, input logic [15:0] bits, input int nb, input int idx,
                         input int stop_at, input string tag);
        int ok;
        int bz;
        bz = 0;
        check({tag, "_idx"}, 32'(idx_o[k]), 32'(idx));
        for (int j = 0; j < nb; j++) begin
            ok = 0;
            for (int c = 0; c < 10; c++) begin
                if (tx_o[k] === bits[j]) ok++;
                if (busy_o[k] === 1'b1 && done_o[k] === 1'b0) bz++;
                stop_req[k] = (j == stop_at) && (c == 0);
                @(negedge clk);
            end
            check($sformatf("%s_b%0d", tag, j), ok, 10);
        end
        check({tag, "_busy"}, bz, nb * 10);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; wr_en[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0;
            msg_len[k] = '0; start[k] = 1'b0; stop_req[k] = 1'b0;
        end
        exp_mem[0] = 8'h48; exp_mem[1] = 8'h69; exp_mem[2] = 8'h21; exp_mem[3] = 8'hA5;
        for (int i = 4; i < 16; i++) exp_mem[i] = 8'(i * 37 + 5);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_tx%0d", k), tx_o[k], 1);
            check($sformatf("rst_busy%0d", k), busy_o[k], 0);
            check($sformatf("rst_done%0d", k), done_o[k], 0);
            check($sformatf("rst_idx%0d", k), idx_o[k], 0);
        end

        // "Hi" on 8N1
        wr(0, 0, 8'h48);
        wr(0, 1, 8'h69);
        kick(0, 2, 1'b0);
        frame(0, {6'b0, 1'b1, 8'h48, 1'b0}, 10, 0, -1, "hi_c0");
        frame(0, {6'b0, 1'b1, 8'h69, 1'b0}, 10, 1, -1, "hi_c1");
        check("hi_done", done_o[0], 1);
        check("hi_busy_end", busy_o[0], 0);
        @(negedge clk);
        check("hi_done_pulse", done_o[0], 0);

        // 7E2, bit 7 of the written byte must not be sent
        wr(1, 0, 8'hC1);
        kick(1, 1, 1'b0);
        frame(1, {5'b0, 2'b11, 1'b0, 7'h41, 1'b0}, 11, 0, -1, "e72");
        check("e72_done", done_o[1], 1);
        check("e72_busy_end", busy_o[1], 0);

        // zero-length message
        kick(0, 0, 1'b0);
        check("len0_done", done_o[0], 1);
        check("len0_busy", busy_o[0], 0);
        check("len0_tx", tx_o[0], 1);
        @(negedge clk);
        check("len0_done_pulse", done_o[0], 0);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (tx_o[0] !== 1'b1 || busy_o[0] !== 1'b0) n++;
            @(negedge clk);
        end
        check("len0_quiet", n, 0);

        // odd parity with auto repeat, gap, then stop_req mid-frame
        wr(2, 0, 8'h00);
        kick(2, 1, 1'b0);
        frame(2, {5'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11, 0, -1, "odd_r0");
        check("rep_done0", done_o[2], 1);
        check("rep_busy_gap", busy_o[2], 1);
        n = 0;
        while (tx_o[2] === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("gap_len", n, 50);
        frame(2, {5'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11, 0, 3, "odd_r1");
        check("stop_done", done_o[2], 1);
        check("stop_busy", busy_o[2], 0);
        n = 0;
        for (int c = 0; c < 80; c++) begin
            if (tx_o[2] !== 1'b1 || busy_o[2] !== 1'b0) n++;
            @(negedge clk);
        end
        check("stop_idle", n, 0);

        // write while busy ignored; reset mid data bit
        wr(0, 2, 8'h21);
        wr(0, 3, 8'hA5);
        kick(0, 1, 1'b0);
        wr(0, 3, 8'h3C);
        repeat (12) @(negedge clk);
        check("pre_rst_tx", tx_o[0], 0);
        check("pre_rst_busy", busy_o[0], 1);
        rst[0] = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", tx_o[0], 1);
        check("mid_rst_busy", busy_o[0], 0);
        check("mid_rst_idx", idx_o[0], 0);
        rst[0] = 1'b0;
        kick(0, 4, 1'b0);
        for (int i = 0; i < 4; i++)
            frame(0, {6'b0, 1'b1, exp_mem[i], 1'b0}, 10, i, -1, $sformatf("wr_c%0d", i));
        check("wr_done", done_o[0], 1);

        // start held high, length clamped to depth
        for (int i = 4; i < 16; i++) wr(0, i, exp_mem[i]);
        kick(0, 19, 1'b1);
        for (int i = 0; i < 16; i++)
            frame(0, {6'b0, 1'b1, exp_mem[i], 1'b0}, 10, i, -1, $sformatf("cl_c%0d", i));
        check("clamp_done", done_o[0], 1);
        check("clamp_busy", busy_o[0], 0);
        start[0] = 1'b0;
        @(negedge clk);
        check("clamp_idle", busy_o[0], 0);
        check("clamp_tx", tx_o[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_msg_tx.md
# uart_msg_tx

Parametrised UART message transmitter, the successor to the fixed-string credits transmitter. It holds up to `MSG_DEPTH` characters in an internal writable buffer. On request it serialises a runtime-selected number of them as UART frames with configurable data width, parity and stop bits. It sits beside the CPU as a status/credits/debug output and can optionally repeat the message autonomously with a programmable gap.

## Interface
- `CLK_FREQ`, 10000000, clock frequency in Hz
- `BAUD_RATE`, 115200, line rate; `BAUD_DIV = CLK_FREQ / BAUD_RATE` (truncating), must be ≥ 2
- `MSG_DEPTH`, 16, buffer entries; `AW = clog2(MSG_DEPTH)`
- `DATA_BITS`, 8, data bits per frame, 5..8
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, 1 or 2
- `GAP_CYCLES`, 100000, idle clocks between repeats in auto mode
- `AUTO_REPEAT`, 0, 1 = retransmit forever after first `start`
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `wr_en` input 1: buffer write strobe
- `wr_addr` input AW: buffer write address
- `wr_data` input 8: character; only bits [DATA_BITS-1:0] are sent
- `msg_len` input AW+1: characters to send, sampled on accepted `start`
- `start` input 1: transmit request
- `stop_req` input 1: finish the current frame, then return to idle
- `tx` output 1: serial line, idle high
- `busy` output 1: high from the cycle after an accepted start until return to IDLE
- `char_idx` output AW: index of the character being sent
- `done` output 1: one-cycle pulse at message end

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `char_idx`=0, state IDLE, all counters 0. Buffer contents are not reset.
- Writes are accepted only when `busy`=0. Writes while busy are ignored. `wr_addr` ≥ `MSG_DEPTH` is ignored.
- States: IDLE → START_BIT → DATA → [PARITY] → STOP → (next char: START_BIT | end: GAP or IDLE); GAP → START_BIT.
- IDLE: `start`=1 latches `msg_len` and moves to START_BIT with `char_idx`=0.
  - If the latched length is 0, do not move: pulse `done` next cycle and stay IDLE.
  - `msg_len` > `MSG_DEPTH` is clamped to `MSG_DEPTH`.
- START_BIT: `tx`=0. DATA: LSB first, `DATA_BITS` bits. PARITY (only if `PARITY`≠0): odd/even parity over the sent data bits. STOP: `tx`=1 for `STOP_BITS` bit times.
- Every bit lasts exactly `BAUD_DIV` clocks. There is no extra cycle per bit and no inter-character gap.
- End of last STOP: pulse `done`.
  - `AUTO_REPEAT`=0 or `stop_req` seen: go to IDLE.
  - Otherwise go to GAP for `GAP_CYCLES` clocks (`tx`=1), then restart at `char_idx`=0 with the same latched length.
- `stop_req` is sticky until IDLE. It never truncates a frame. The current character completes, then `done` pulses and the block returns to IDLE.
- `start` while busy is ignored. `stop_req` in IDLE is ignored.
- `rst` mid-frame: next cycle `tx`=1, `busy`=0, state IDLE. The partial frame is abandoned.

## Timing
- Accepted `start` at edge N: `busy`=1 and `tx`=0 from edge N+1.
- Frame length F = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.
- Message of L chars: `done` is high in the cycle after the final stop bit ends, i.e. edge N+1+L·F·BAUD_DIV. `busy` drops in the same cycle (non-repeat).
- `char_idx` increments on the cycle the next START_BIT begins.
- GAP duration is exactly `GAP_CYCLES` clocks between the end of the last stop bit and the next start bit.
- Baud counter counts 0..BAUD_DIV-1. It is 32 bits wide and wraps to 0 at each bit boundary.

## Structure
- Shared package `uart_pkg`:
  - state enum
  - parity encoding constants (NONE/ODD/EVEN)
  - function `frame_bits(DATA_BITS, PARITY, STOP_BITS)`
- Sub-module `uart_baud_gen`:
  - parameter `DIV`
  - inputs `clk`, `rst`, `clr`
  - output `tick` pulsing once per `DIV` clocks
  - `clr` realigns the count on a start bit
- Buffer is a plain register array, one write port and one async read port.

## Test plan
1. CLK_FREQ=10e6, BAUD_RATE=1e6, 8N1: write "Hi" (0x48, 0x69), `msg_len`=2, `start`. Expect:
   - `tx` low 10 clocks, then 0x48 LSB-first at 10 clocks/bit, stop, then 0x69
   - `done` at N+1+200
   - `busy`=0 after `done`
2. DATA_BITS=7, PARITY=2 (even), STOP_BITS=2: send 0x41. Expect bits 1,0,0,0,0,0,1, parity 0, two stop bits, F=11 (110 clocks).
3. PARITY=1 (odd) with 0x00. Expect parity bit 1. `msg_len`=0 → `done` pulse, `tx` never low, `busy` stays 0.
4. AUTO_REPEAT=1, GAP_CYCLES=50, `msg_len`=1. Expect:
   - `done` after each frame
   - exactly 50 high clocks before the next start bit
   - `stop_req` mid-frame completes that frame, then IDLE
5. `rst` asserted mid DATA bit → `tx`=1, `busy`=0 next cycle. A write to address 3 while busy is ignored, verified by a later send.
6. `start` asserted continuously while busy → no second message until IDLE. `msg_len`=MSG_DEPTH+3 → exactly MSG_DEPTH characters sent.
